// File: rtl/gf2n_pkg.sv
// GF(2^N) helpers shared by the masked multiplier: field product, mask-pair indexing
// and the fresh-mask width for a given field width and share count.
package gf2n_pkg;

    localparam int MAX_N = 8;

    function automatic int nz(input int n, input int shares);
        return n * shares * (shares - 1) / 2;
    endfunction

    // Row-major index of the unordered share pair (i,j), i<j.
    function automatic int pair_idx(input int i, input int j, input int shares);
        return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic logic [MAX_N-1:0] gf2n_mul(input logic [MAX_N-1:0] a,
                                                  input logic [MAX_N-1:0] b,
                                                  input logic [MAX_N:0]   poly,
                                                  input int               n);
        logic [2*MAX_N-1:0] p;
        p = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && b[i]) p = p ^ ({{MAX_N{1'b0}}, a} << i);
        end
        for (int i = 2*MAX_N-2; i >= 0; i--) begin
            if (i >= n && i <= 2*n-2 && p[i])
                p = p ^ ({{(MAX_N-1){1'b0}}, poly} << (i - n));
        end
        return p[MAX_N-1:0];
    endfunction

endpackage

// File: rtl/gf2n_mul.sv
// Combinational polynomial-basis GF(2^N) multiplier: carry-less product reduced mod POLY.
module gf2n_mul #(
    parameter int         N    = 2,
    parameter logic [N:0] POLY = 3'b111
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    localparam int W = 2*N - 1;

    logic [W-1:0] prod;

    always_comb begin
        prod = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) prod = prod ^ (W'(a) << i);
        end
        // Fold the high coefficients back down, top bit first.
        for (int i = W-1; i >= N; i--) begin
            if (prod[i]) prod = prod ^ (W'(POLY) << (i - N));
        end
        p = prod[N-1:0];
    end

endmodule

// File: rtl/shared_mul_gf2n_hs.sv
// DOM-indep masked GF(2^N) multiplier with operand, fresh-mask and output handshakes.
// Stage 1 holds one register per (i,j) term; stage 2 compresses each domain into its output share.
module shared_mul_gf2n_hs
    import gf2n_pkg::*;
#(
    parameter int         N      = 2,
    parameter logic [N:0] POLY   = 3'b111,
    parameter int         SHARES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*SHARES-1:0]       x,
    input  logic [N*SHARES-1:0]       y,
    input  logic                      z_valid,
    output logic                      z_ready,
    input  logic [nz(N,SHARES)-1:0]   z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*SHARES-1:0]       q
);

    localparam int NT = SHARES * SHARES;

    logic              v1;
    logic              v2;
    logic              accept;
    logic              adv2;
    logic [N-1:0]      term_d [NT];
    logic [N-1:0]      term_q [NT];
    logic [N*SHARES-1:0] q_d;

    assign in_ready  = !v1 || !v2 || out_ready;
    // Masks are only consumed when an operand pair is actually taken, never during reset.
    assign accept    = in_valid && z_valid && in_ready && rst_n;
    assign z_ready   = accept;
    assign adv2      = v1 && (!v2 || out_ready);
    assign out_valid = v2;

    for (genvar gi = 0; gi < SHARES; gi++) begin : g_row
        for (genvar gj = 0; gj < SHARES; gj++) begin : g_col
            logic [N-1:0] prod;

            gf2n_mul #(.N(N), .POLY(POLY)) u_mul (
                .a (x[gi*N +: N]),
                .b (y[gj*N +: N]),
                .p (prod)
            );

            if (gi == gj) begin : g_inner
                assign term_d[gi*SHARES+gj] = prod;
            end else if (gi < gj) begin : g_upper
                assign term_d[gi*SHARES+gj] = prod ^ z[pair_idx(gi, gj, SHARES)*N +: N];
            end else begin : g_lower
                assign term_d[gi*SHARES+gj] = prod ^ z[pair_idx(gj, gi, SHARES)*N +: N];
            end
        end
    end

    always_comb begin
        q_d = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                q_d[i*N +: N] = q_d[i*N +: N] ^ term_q[i*SHARES+j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            q  <= '0;
            for (int k = 0; k < NT; k++) term_q[k] <= '0;
        end else begin
            if (accept)     v1 <= 1'b1;
            else if (adv2)  v1 <= 1'b0;

            if (adv2)           v2 <= 1'b1;
            else if (out_ready) v2 <= 1'b0;

            if (accept) begin
                for (int k = 0; k < NT; k++) term_q[k] <= term_d[k];
            end
            if (adv2) q <= q_d;
        end
    end

endmodule

// File: tb/tb_shared_mul_gf2n_hs.sv
// Self-checking bench: behavioural queue model of the 2-deep pipeline plus a reference
// GF(2^N) multiply, run on a 2-share GF(4) instance and a 3-share GF(16) instance.
module tb_shared_mul_gf2n_hs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, z_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, z_ready, out_valid;
    logic [3:0]  x = '0, y = '0, q;
    logic [1:0]  z = '0;

    logic        rst3_n = 1'b0;
    logic        in_valid3 = 1'b0, z_valid3 = 1'b0, out_ready3 = 1'b1;
    logic        in_ready3, z_ready3, out_valid3;
    logic [11:0] x3 = '0, y3 = '0, z3 = '0, q3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shared_mul_gf2n_hs #(.N(2), .POLY(3'b111), .SHARES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z_valid(z_valid), .z_ready(z_ready), .z(z),
        .out_valid(out_valid), .out_ready(out_ready), .q(q)
    );

    shared_mul_gf2n_hs #(.N(4), .POLY(5'b10011), .SHARES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .x(x3), .y(y3), .z_valid(z_valid3), .z_ready(z_ready3), .z(z3),
        .out_valid(out_valid3), .out_ready(out_ready3), .q(q3)
    );

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Shift-and-add with reduction whenever the running multiplicand overflows.
    function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b,
                                            input int n, input int unsigned poly);
        int unsigned r = 0;
        for (int i = 0; i < n; i++) begin
            if (b & 1) r ^= a;
            b = b >> 1;
            a = a << 1;
            if (a & (32'd1 << n)) a ^= poly;
        end
        return r;
    endfunction

    function automatic int unsigned xor_shares(input int unsigned v, input int n, input int s);
        int unsigned r = 0;
        for (int i = 0; i < s; i++) r ^= (v >> (i*n)) & ((32'd1 << n) - 1);
        return r;
    endfunction

    typedef struct { int cyc; int unsigned prod; } item_t;

    item_t       mq[$];
    int          cyc = 0;
    bit          hold_valid = 0;
    logic [3:0]  hold_q = '0;
    int          pops = 0, accs = 0, first_pop = -1, last_pop = -1, first_acc = -1;

    always @(negedge clk) begin
        bit exp_rdy, exp_ov;
        cyc++;
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_q", 32'(q), 0);
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_z_ready", 32'(z_ready), 0);
            mq.delete();
            hold_valid = 0;
        end else begin
            exp_rdy = (mq.size() < 2) || out_ready;
            exp_ov  = (mq.size() > 0) && (mq[0].cyc <= cyc - 2);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("z_ready", 32'(z_ready), 32'(in_valid && z_valid && exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (out_valid && exp_ov) chk("product", xor_shares(32'(q), 2, 2), mq[0].prod);
            if (hold_valid && out_valid) chk("hold_stable", 32'(q), 32'(hold_q));
            hold_valid = out_valid && !out_ready;
            hold_q     = q;
            if (exp_ov && out_ready) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                void'(mq.pop_front());
            end
            if (in_valid && z_valid && exp_rdy) begin
                accs++;
                if (first_acc < 0) first_acc = cyc;
                mq.push_back('{cyc, ref_mul(xor_shares(32'(x), 2, 2),
                                            xor_shares(32'(y), 2, 2), 2, 32'h7)});
            end
        end
    end

    item_t mq3[$];
    int    pops3 = 0, accs3 = 0, diff3 = 0;
    bit    done3 = 0;

    always @(negedge clk) begin
        bit exp_ov3;
        if (!rst3_n) begin
            mq3.delete();
        end else begin
            exp_ov3 = (mq3.size() > 0) && (mq3[0].cyc <= cyc - 2);
            chk("g_in_ready", 32'(in_ready3), 1);
            chk("g_out_valid", 32'(out_valid3), 32'(exp_ov3));
            if (out_valid3 && exp_ov3) begin
                chk("g_product", xor_shares(32'(q3), 4, 3), mq3[0].prod);
                if (32'(q3[3:0]) != mq3[0].prod) diff3++;
            end
            if (exp_ov3) begin
                pops3++;
                void'(mq3.pop_front());
            end
            if (in_valid3 && z_valid3) begin
                accs3++;
                mq3.push_back('{cyc, ref_mul(xor_shares(32'(x3), 4, 3),
                                             xor_shares(32'(y3), 4, 3), 4, 32'h13)});
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst3_n = 1'b1;
        n = 0;
        while (accs3 < 1000 && n < 5000) begin
            in_valid3 = 1'($urandom_range(0, 3) != 0);
            z_valid3  = 1'($urandom_range(0, 3) != 0);
            x3 = 12'($urandom);
            y3 = 12'($urandom);
            z3 = 12'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid3 = 1'b0;
        z_valid3  = 1'b0;
        repeat (4) @(posedge clk);
        chk("g_count", 32'(pops3), 1000);
        tests++;
        if (diff3 < 880 || diff3 > 995) begin
            fails++;
            $display("FAIL g_share_uniform: got %0d differing of 1000 expected 880..995", diff3);
        end
        done3 = 1;
    end

    task automatic send(input logic [3:0] xv, input logic [3:0] yv);
        int n = 0;
        x = xv; y = yv; z = 2'($urandom);
        in_valid = 1'b1; z_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        pops = 0; accs = 0; first_pop = -1; last_pop = -1; first_acc = -1;
    endtask

    initial begin
        int n;
        chk("ref_2x2", ref_mul(2, 2, 2, 32'h7), 3);
        chk("ref_2x3", ref_mul(2, 3, 2, 32'h7), 1);
        chk("ref_3x3", ref_mul(3, 3, 2, 32'h7), 2);
        chk("ref16_x_x3", ref_mul(2, 8, 4, 32'h13), 3);

        in_valid = 1'b1; z_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0; z_valid = 1'b0;
        @(posedge clk); #1;

        // Exhaustive share combinations with a free-running output.
        out_ready = 1'b1;
        for (int v = 0; v < 256; v++) send(4'(v), 4'(v >> 4));
        in_valid = 1'b0; z_valid = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Ten back-to-back products.
        clear_counts();
        for (int i = 0; i < 10; i++) send(4'($urandom), 4'($urandom));
        in_valid = 1'b0; z_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("lat_count", 32'(pops), 10);
        chk("lat_first", 32'(first_pop), 32'(first_acc + 2));
        chk("lat_last", 32'(last_pop), 32'(first_acc + 11));

        // Output stall with operands still offered.
        clear_counts();
        out_ready = 1'b0;
        in_valid = 1'b1; z_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = 4'($urandom); y = 4'($urandom); z = 2'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_accs", 32'(accs), 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; z_valid = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("drain_pops", 32'(pops), 3);
        chk("drain_accs", 32'(accs), 3);

        // Randomness starvation.
        clear_counts();
        in_valid = 1'b1; z_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("starve_z_ready", 32'(z_ready), 0);
        end
        @(posedge clk); #1;
        z_valid = 1'b1;
        @(negedge clk);
        chk("fed_z_ready", 32'(z_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; z_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("starve_accs", 32'(accs), 1);
        chk("starve_pops", 32'(pops), 1);

        // Random handshake traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            z_valid   = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            x = 4'($urandom); y = 4'($urandom); z = 2'($urandom);
            @(posedge clk); #1;
        end

        // Reset while both stages hold data.
        out_ready = 1'b0;
        in_valid = 1'b1; z_valid = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_q", 32'(q), 0);
        chk("async_in_ready", 32'(in_ready), 1);
        chk("async_z_ready", 32'(z_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0; z_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        clear_counts();
        repeat (5) @(posedge clk); #1;
        chk("post_rst_pops", 32'(pops), 0);

        n = 0;
        while (!done3 && n < 8000) begin
            @(posedge clk);
            n++;
        end
        if (!done3) begin
            tests++; fails++;
            $display("FAIL g_timeout: got done 0 expected 1 within 8000 cycles");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
